ds_pwm_decimator: RTL and testbench

//  Receive-side counterpart of the ternary delta-sigma PWM output. Decodes one 2-bit
//  PWM channel (01=+1, 11=-1, 00=0) back to signed multibit samples via a CIC
//  (sinc^ORDER) decimator at the modulator OSR. Used in loopback/self-check paths
//  to compare beamformer PWM outputs against the original vin_i/vin_q samples.

---
 rtl/ds_pwm_decimator_if.sv | 22 ++
 rtl/ds_pwm_decimator.sv | 107 ++++++++++
 tb/tb_ds_pwm_decimator.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/ds_pwm_decimator_if.sv
// Stream bundle between a ternary PWM source and the CIC decimator: input code,
// accept strobe, datapath restart, decimated output and error flag.
interface ds_pwm_decimator_if #(
  parameter int OUT_W = 10
);
  logic                    restart;
  logic [1:0]              pwm_in;
  logic                    in_valid;
  logic signed [OUT_W-1:0] dout;
  logic                    dout_valid;
  logic                    code_err;

  modport master (
    output restart, pwm_in, in_valid,
    input  dout, dout_valid, code_err
  );

  modport slave (
    input  restart, pwm_in, in_valid,
    output dout, dout_valid, code_err
  );
endinterface

// File: rtl/ds_pwm_decimator.sv
// Ternary PWM decoder followed by a sinc^ORDER CIC decimator (ratio 2^LOG2_R)
// producing saturated signed samples for loopback comparison.
module ds_pwm_decimator #(
  parameter int ORDER  = 3,
  parameter int LOG2_R = 3,
  parameter int OUT_W  = 10
) (
  input  logic               clock,
  input  logic               reset,
  ds_pwm_decimator_if.slave  io
);

  localparam int ACC_W = 2 + ORDER * LOG2_R;
  localparam int SHIFT = ORDER * LOG2_R + 1 - OUT_W;
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

  function automatic logic signed [OUT_W-1:0] scale_sat(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] y;
    y = v >>> SHIFT;
    if (y > OUT_MAX)
      y = OUT_MAX;
    else if (y < OUT_MIN)
      y = OUT_MIN;
    return y[OUT_W-1:0];
  endfunction

  logic signed [ACC_W-1:0] x;
  logic signed [ACC_W-1:0] integ_p0 [ORDER];
  logic signed [ACC_W-1:0] integ_nxt [ORDER];
  logic signed [ACC_W-1:0] dly_p1 [ORDER];
  logic signed [ACC_W-1:0] dly_nxt [ORDER];
  logic signed [ACC_W-1:0] int_acc;
  logic signed [ACC_W-1:0] comb_acc;
  logic [LOG2_R-1:0]       phase_p0;
  logic                    dec_p0;
  logic signed [OUT_W-1:0] dout_p1;
  logic                    vld_p1;
  logic                    code_err;

  always_comb begin
    x = '0;
    case (io.pwm_in)
      2'b01:   x = ACC_W'(1);
      2'b11:   x = '1;
      default: x = '0;
    endcase
  end

  // Integrator cascade settles within one edge; comb reads iN as registered.
  always_comb begin
    int_acc = x;
    for (int k = 0; k < ORDER; k++) begin
      int_acc      = integ_p0[k] + int_acc;
      integ_nxt[k] = int_acc;
    end
    comb_acc = integ_p0[ORDER-1];
    for (int k = 0; k < ORDER; k++) begin
      dly_nxt[k] = comb_acc;
      comb_acc   = comb_acc - dly_p1[k];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int k = 0; k < ORDER; k++) begin
        integ_p0[k] <= '0;
        dly_p1[k]   <= '0;
      end
      phase_p0 <= '0;
      dec_p0   <= 1'b0;
      dout_p1  <= '0;
      vld_p1   <= 1'b0;
      code_err <= 1'b0;
    end else if (io.restart) begin
      for (int k = 0; k < ORDER; k++) begin
        integ_p0[k] <= '0;
        dly_p1[k]   <= '0;
      end
      phase_p0 <= '0;
      dec_p0   <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      // stage 0: decode, integrate, track decimation phase
      dec_p0 <= 1'b0;
      if (io.in_valid) begin
        integ_p0 <= integ_nxt;
        phase_p0 <= phase_p0 + LOG2_R'(1);
        dec_p0   <= &phase_p0;
        if (io.pwm_in == 2'b10)
          code_err <= 1'b1;
      end
      // stage 1: comb at the decimated rate, scale and saturate
      vld_p1 <= 1'b0;
      if (dec_p0) begin
        dly_p1  <= dly_nxt;
        dout_p1 <= scale_sat(comb_acc);
        vld_p1  <= 1'b1;
      end
    end
  end

  assign io.dout       = dout_p1;
  assign io.dout_valid = vld_p1;
  assign io.code_err   = code_err;

endmodule

// File: tb/tb_ds_pwm_decimator.sv
// Directed bench for ds_pwm_decimator: reset, constant +/-1 streams, gapped input,
// illegal code handling and restart behaviour against hand-computed CIC outputs.
module tb_ds_pwm_decimator;

  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;

  ds_pwm_decimator_if #(.OUT_W(10)) io ();

  ds_pwm_decimator #(.ORDER(3), .LOG2_R(3), .OUT_W(10)) dut (
    .clock (clock),
    .reset (reset),
    .io    (io.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic rst_n, input logic rs, input logic v, input logic [1:0] code);
    reset       = rst_n;
    io.restart  = rs;
    io.in_valid = v;
    io.pwm_in   = code;
  endtask

  // Restart cycle carrying a valid sample that must be discarded, then a stream.
  task automatic run_stream(input string tag, input logic [1:0] code, input bit gapped,
                            input int e0, input int e1, input int e2, input int e3);
    int exp_v [4];
    int period;
    int first;
    int got;
    int last_c;
    exp_v  = '{e0, e1, e2, e3};
    period = gapped ? 16 : 8;
    first  = gapped ? 15 : 8;
    got    = 0;
    last_c = 0;
    drive(1'b1, 1'b1, 1'b1, code);
    step();
    chk({tag, "_restart_vld"}, int'(io.dout_valid), 0);
    for (int c = 0; c < 4 * period + 10 && got < 4; c++) begin
      drive(1'b1, 1'b0, gapped ? (c % 2 == 0) : 1'b1, code);
      step();
      if (io.dout_valid) begin
        chk($sformatf("%s_val%0d", tag, got), int'(io.dout), exp_v[got]);
        chk($sformatf("%s_time%0d", tag, got), c, (got == 0) ? first : last_c + period);
        last_c = c;
        got++;
      end
    end
    chk({tag, "_count"}, got, 4);
    drive(1'b1, 1'b0, 1'b0, 2'b00);
    step();
    chk({tag, "_hold"}, int'(io.dout), e3);
  endtask

  initial begin
    int strobes;
    vectors     = 0;
    miscompares = 0;
    drive(1'b0, 1'b0, 1'b0, 2'b00);

    // Reset held with random activity on every input.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)));
      step();
      chk($sformatf("rst_dout%0d", i), int'(io.dout), 0);
      chk($sformatf("rst_vld%0d", i), int'(io.dout_valid), 0);
      chk($sformatf("rst_err%0d", i), int'(io.code_err), 0);
    end

    // Zeros, then one illegal code; error is sticky.
    strobes = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 1'b1, 2'b00);
      step();
      if (io.dout_valid) strobes++;
    end
    chk("zero_strobes", strobes, 1);
    chk("zero_dout", int'(io.dout), 0);
    chk("err_before", int'(io.code_err), 0);
    drive(1'b1, 1'b0, 1'b1, 2'b10);
    step();
    chk("err_rise", int'(io.code_err), 1);
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 1'b0, 1'b1, 2'b00);
      step();
    end
    chk("err_sticky", int'(io.code_err), 1);
    chk("err_dout", int'(io.dout), 0);

    // Partial frame then restart: no output may appear from the partial data.
    drive(1'b1, 1'b1, 1'b0, 2'b00);
    step();
    strobes = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b1, 2'b01);
      step();
      if (io.dout_valid) strobes++;
    end
    drive(1'b1, 1'b1, 1'b0, 2'b01);
    step();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b1, 2'b01);
      step();
      if (io.dout_valid) strobes++;
    end
    chk("partial_strobes", strobes, 0);
    // Restart on the edge where the comb strobe is pending cancels it.
    drive(1'b1, 1'b1, 1'b1, 2'b01);
    step();
    chk("cancel_vld", int'(io.dout_valid), 0);
    chk("cancel_dout", int'(io.dout), 0);
    drive(1'b1, 1'b0, 1'b0, 2'b01);
    step();
    chk("cancel_vld2", int'(io.dout_valid), 0);

    run_stream("pos", 2'b01, 1'b0, 120, 456, 511, 511);
    chk("err_kept", int'(io.code_err), 1);

    drive(1'b0, 1'b0, 1'b0, 2'b00);
    step();
    step();
    chk("rst2_err", int'(io.code_err), 0);
    chk("rst2_dout", int'(io.dout), 0);

    run_stream("neg", 2'b11, 1'b0, -120, -456, -512, -512);
    run_stream("gap", 2'b01, 1'b1, 120, 456, 511, 511);
    chk("final_err", int'(io.code_err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
